stack_controller: RTL and testbench

Sequencer for the CTI-8 stack-pointer counter and the stack page of data memory. It accepts one stack operation at a time from the core control unit: push, pop, call, return, load SP, or read SP. It drives the counter's oe/wr/dir/en controls, its shared data bus, and the memory strobes needed to complete each operation. It also detects stack overflow and underflow before touching any state.

---
 rtl/stack_controller_pkg.sv | 36 +++
 rtl/stack_controller_if.sv | 13 +
 rtl/stack_controller.sv | 163 ++++++++++++++++
 tb/tb_stack_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_controller_pkg.sv
// Shared constants for the CTI-8 stack sequencer: op codes, SP limits, FSM states
// and the acceptance-time rejection rule.
package stack_ctrl_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_LDSP = 3'd4;
  localparam logic [2:0] OP_RDSP = 3'd5;

  localparam logic [7:0] SP_FULL  = 8'h00;
  localparam logic [7:0] SP_EMPTY = 8'hFF;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PSH, S_INC, S_RD, S_CAP, S_LOAD, S_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]  code;
    logic [15:0] data;
  } stack_req_t;

  // Occupied bytes are FF..01, so SP==00 is full and SP==FF is empty.
  function automatic logic op_reject(input logic [2:0] code, input logic [7:0] sp);
    case (code)
      OP_PUSH:          return sp == SP_FULL;
      OP_CALL:          return sp <= 8'h01;
      OP_POP:           return sp == SP_EMPTY;
      OP_RET:           return sp >= 8'hFE;
      OP_LDSP, OP_RDSP: return 1'b0;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Request/response handshake between the core control unit and the stack sequencer.
interface stack_controller_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] op_data;
  logic        op_ready;
  logic        done;
  logic        err;
  logic [15:0] rdata;

  modport master (output op_valid, op_code, op_data, input op_ready, done, err, rdata);
  modport slave  (input op_valid, op_code, op_data, output op_ready, done, err, rdata);
endinterface

// File: rtl/stack_controller.sv
// Sequences the SP counter and stack-page memory strobes for PUSH/POP/CALL/RET/LDSP/RDSP,
// rejecting overflow/underflow at acceptance before any state is touched.
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  stack_controller_if.slave  ctl,
  output logic               sp_oe,
  output logic               sp_wr,
  output logic               sp_dir,
  output logic               sp_en,
  input  logic [7:0]         sp_addr,
  output logic [7:0]         bus_out,
  output logic               bus_drive_en,
  output logic [15:0]        mem_addr,
  output logic               mem_we,
  output logic [7:0]         mem_wdata,
  output logic               mem_re,
  input  logic [7:0]         mem_rdata
);

  state_e     state_q, state_d;
  logic       phase_q, phase_d;
  stack_req_t req_q;
  logic       err_q;
  logic [7:0] lo_q;
  logic [15:0] rdata_q;

  logic       accept, reject;
  logic       cap_lo, cap_pop, cap_ret;
  logic       wr_c, en_c, we_c, re_c, drive_c;
  logic [7:0] bus_c;
  logic       is_call, is_ret;

  assign is_call = req_q.code == OP_CALL;
  assign is_ret  = req_q.code == OP_RET;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      phase_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    accept    = 1'b0;
    reject    = 1'b0;
    cap_lo    = 1'b0;
    cap_pop   = 1'b0;
    cap_ret   = 1'b0;
    wr_c      = 1'b0;
    en_c      = 1'b0;
    we_c      = 1'b0;
    re_c      = 1'b0;
    drive_c   = 1'b0;
    bus_c     = 8'h00;
    sp_dir    = 1'b0;
    mem_wdata = 8'h00;
    unique case (state_q)
      S_INIT: begin
        bus_c   = SP_EMPTY;
        drive_c = 1'b1;
        wr_c    = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (ctl.op_valid) begin
          accept  = 1'b1;
          reject  = op_reject(ctl.op_code, sp_addr);
          phase_d = 1'b0;
          if (reject) state_d = S_DONE;
          else begin
            case (ctl.op_code)
              OP_PUSH, OP_CALL: state_d = S_PSH;
              OP_POP, OP_RET:   state_d = S_INC;
              OP_LDSP:          state_d = S_LOAD;
              default:          state_d = S_DONE;
            endcase
          end
        end
      end
      S_PSH: begin
        // CALL pushes the high byte first so it lands at the higher address.
        we_c      = 1'b1;
        mem_wdata = (is_call && !phase_q) ? req_q.data[15:8] : req_q.data[7:0];
        en_c      = 1'b1;
        sp_dir    = 1'b1;
        if (is_call && !phase_q) phase_d = 1'b1;
        else                     state_d = S_DONE;
      end
      S_INC: begin
        en_c    = 1'b1;
        state_d = S_RD;
      end
      S_RD: begin
        re_c    = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        if (is_ret && !phase_q) begin
          cap_lo  = 1'b1;
          en_c    = 1'b1;
          phase_d = 1'b1;
          state_d = S_RD;
        end else begin
          cap_pop = !is_ret;
          cap_ret = is_ret;
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        bus_c   = req_q.data[7:0];
        drive_c = 1'b1;
        wr_c    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  // RET's low byte is parked in lo_q so rdata only changes once the full address is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      lo_q    <= 8'h00;
      rdata_q <= 16'h0000;
    end else if (clk_en) begin
      if (accept) begin
        req_q <= '{code: ctl.op_code, data: ctl.op_data};
        err_q <= reject;
        if (!reject && ctl.op_code == OP_RDSP) rdata_q <= {8'h00, sp_addr};
      end
      if (cap_lo)  lo_q    <= mem_rdata;
      if (cap_pop) rdata_q <= {8'h00, mem_rdata};
      if (cap_ret) rdata_q <= {mem_rdata, lo_q};
    end
  end

  assign sp_oe        = 1'b0;
  assign sp_wr        = wr_c & clk_en & ~rst;
  assign sp_en        = en_c & clk_en & ~rst;
  assign mem_we       = we_c & clk_en & ~rst;
  assign mem_re       = re_c & clk_en & ~rst;
  assign bus_drive_en = drive_c & ~rst;
  assign bus_out      = rst ? 8'h00 : bus_c;
  assign mem_addr     = {STACK_PAGE, sp_addr};

  assign ctl.op_ready = state_q == S_IDLE;
  assign ctl.done     = state_q == S_DONE;
  assign ctl.err      = (state_q == S_DONE) & err_q;
  assign ctl.rdata    = rdata_q;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench: SP counter + stack memory models, a stack-level reference
// model, directed boundary steps and a randomized op stream.
module tb_stack_controller;
  import stack_ctrl_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  logic        sp_oe, sp_wr, sp_dir, sp_en, bus_drive_en, mem_we, mem_re;
  logic [7:0]  sp_addr = 8'h5A, bus_out, mem_wdata, mem_rdata = 8'h00;
  logic [15:0] mem_addr;
  logic        mem_clr = 1'b1, toggle = 1'b0, mon_on = 1'b0;

  stack_controller_if ctl();

  stack_controller #(.STACK_PAGE(8'h01)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ctl(ctl),
    .sp_oe(sp_oe), .sp_wr(sp_wr), .sp_dir(sp_dir), .sp_en(sp_en), .sp_addr(sp_addr),
    .bus_out(bus_out), .bus_drive_en(bus_drive_en), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      #1 clk_en = toggle ? ~clk_en : 1'b1;
    end
  end

  // External SP counter and stack page memory.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (sp_wr)      sp_addr <= bus_out;
    else if (sp_en) sp_addr <= sp_dir ? sp_addr - 8'd1 : sp_addr + 8'd1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  int en_cnt = 0, acc_at = 0, acc_ev = 0, done_cnt = 0;
  int we_cnt = 0, re_cnt = 0, spen_cnt = 0, spwr_cnt = 0;
  always @(posedge clk) begin
    if (clk_en) begin
      en_cnt <= en_cnt + 1;
      if (ctl.op_valid && ctl.op_ready) begin
        acc_at <= en_cnt + 1;
        acc_ev <= acc_ev + 1;
      end
      if (ctl.done) done_cnt <= done_cnt + 1;
    end
    we_cnt   <= we_cnt + int'(mem_we);
    re_cnt   <= re_cnt + int'(mem_re);
    spen_cnt <= spen_cnt + int'(sp_en);
    spwr_cnt <= spwr_cnt + int'(sp_wr);
  end

  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("inv_sp_oe", 32'(sp_oe), 0);
      check("inv_en_and_wr", 32'(sp_en & sp_wr), 0);
      check("inv_wr_no_drive", 32'(sp_wr & ~bus_drive_en), 0);
      check("inv_strobe_gated", 32'(~clk_en & (mem_we | mem_re | sp_en | sp_wr)), 0);
      check("mem_addr", 32'(mem_addr), 32'({8'h01, sp_addr}));
    end
  end

  // Reference stack: byte array + SP, updated with the plain stack rules.
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_sp;
  logic [15:0] ref_rd;

  task automatic do_op(input logic [2:0] code, input logic [15:0] data);
    int exp_lat = 1, e_we = 0, e_re = 0, e_spen = 0, e_spwr = 0, nw = 0, n;
    logic rej = 1'b1;
    logic [7:0] wa [2];
    int we0, re0, spen0, spwr0, done0, ev0, en0;
    case (code)
      OP_PUSH: if (ref_sp != 8'h00) begin
        rej = 1'b0; exp_lat = 2; e_we = 1; e_spen = 1;
        ref_mem[ref_sp] = data[7:0]; wa[0] = ref_sp; nw = 1; ref_sp = ref_sp - 8'd1;
      end
      OP_POP: if (ref_sp != 8'hFF) begin
        rej = 1'b0; exp_lat = 4; e_re = 1; e_spen = 1;
        ref_sp = ref_sp + 8'd1; ref_rd = {8'h00, ref_mem[ref_sp]};
      end
      OP_CALL: if (ref_sp > 8'h01) begin
        rej = 1'b0; exp_lat = 3; e_we = 2; e_spen = 2;
        ref_mem[ref_sp] = data[15:8]; ref_mem[ref_sp - 8'd1] = data[7:0];
        wa[0] = ref_sp; wa[1] = ref_sp - 8'd1; nw = 2; ref_sp = ref_sp - 8'd2;
      end
      OP_RET: if (ref_sp < 8'hFE) begin
        rej = 1'b0; exp_lat = 6; e_re = 2; e_spen = 2;
        ref_rd = {ref_mem[ref_sp + 8'd2], ref_mem[ref_sp + 8'd1]}; ref_sp = ref_sp + 8'd2;
      end
      OP_LDSP: begin rej = 1'b0; exp_lat = 2; e_spwr = 1; ref_sp = data[7:0]; end
      OP_RDSP: begin rej = 1'b0; ref_rd = {8'h00, ref_sp}; end
      default: ;
    endcase
    we0 = we_cnt; re0 = re_cnt; spen0 = spen_cnt; spwr0 = spwr_cnt;
    done0 = done_cnt; ev0 = acc_ev;
    ctl.op_valid = 1'b1; ctl.op_code = code; ctl.op_data = data;
    n = 0;
    while (acc_ev == ev0 && n < 200) begin @(negedge clk); n++; end
    ctl.op_valid = 1'b0; ctl.op_code = 3'($urandom); ctl.op_data = 16'($urandom);
    if (acc_ev == ev0) begin check("accept_timeout", 1, 0); return; end
    n = 0;
    while (ctl.done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (ctl.done !== 1'b1) begin check("done_timeout", 1, 0); return; end
    check($sformatf("lat_op%0d", code), 32'(en_cnt - acc_at + 1), 32'(exp_lat));
    check($sformatf("err_op%0d", code), 32'(ctl.err), 32'(rej));
    en0 = en_cnt; n = 0;
    while (en_cnt == en0 && n < 200) begin @(negedge clk); n++; end
    check("done_pulse_end", 32'(ctl.done), 0);
    check("done_count", 32'(done_cnt - done0), 1);
    check($sformatf("rdata_op%0d", code), 32'(ctl.rdata), 32'(ref_rd));
    check($sformatf("sp_op%0d", code), 32'(sp_addr), 32'(ref_sp));
    check("mem_we_count", 32'(we_cnt - we0), 32'(e_we));
    check("mem_re_count", 32'(re_cnt - re0), 32'(e_re));
    check("sp_en_count", 32'(spen_cnt - spen0), 32'(e_spen));
    check("sp_wr_count", 32'(spwr_cnt - spwr0), 32'(e_spwr));
    for (int i = 0; i < nw; i++)
      check($sformatf("mem_%02h", wa[i]), 32'(mem[wa[i]]), 32'(ref_mem[wa[i]]));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] c;
    logic [15:0] d;
    int ev0, done0;
    ctl.op_valid = 1'b0; ctl.op_code = 3'd0; ctl.op_data = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_sp = 8'hFF; ref_rd = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_op_ready", 32'(ctl.op_ready), 0);
    check("rst_done", 32'(ctl.done), 0);
    check("rst_err", 32'(ctl.err), 0);
    check("rst_rdata", 32'(ctl.rdata), 0);
    check("rst_bus_out", 32'(bus_out), 0);
    check("rst_bus_drive", 32'(bus_drive_en), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_strobes", 32'({mem_we, mem_re, sp_en, sp_wr}), 0);
    mem_clr = 1'b0;
    @(posedge clk); #1 rst = 1'b0; mon_on = 1'b1;
    @(negedge clk);
    check("init_sp_wr", 32'(sp_wr), 1);
    check("init_bus_out", 32'(bus_out), 32'hFF);
    check("init_drive", 32'(bus_drive_en), 1);
    check("init_op_ready", 32'(ctl.op_ready), 0);
    @(negedge clk);
    check("idle_op_ready", 32'(ctl.op_ready), 1);
    check("init_sp", 32'(sp_addr), 32'hFF);

    do_op(OP_PUSH, 16'h00A5);
    do_op(OP_LDSP, 16'h00FF);
    do_op(OP_CALL, 16'h1234);
    do_op(OP_RET,  16'h0000);
    do_op(OP_POP,  16'h0000);
    do_op(OP_LDSP, 16'h0000);
    do_op(OP_PUSH, 16'h0077);
    do_op(OP_LDSP, 16'h0001);
    do_op(OP_CALL, 16'h5678);
    do_op(OP_LDSP, 16'h0002);
    do_op(OP_CALL, 16'h9ABC);
    do_op(OP_PUSH, 16'h0011);
    do_op(OP_LDSP, 16'h00FE);
    do_op(OP_RET,  16'h0000);
    do_op(OP_RDSP, 16'h0000);
    do_op(3'd6,    16'h0000);
    do_op(3'd7,    16'h0000);

    do_op(OP_LDSP, 16'h00FF);
    do_op(OP_CALL, 16'hBEEF);
    toggle = 1'b1;
    do_op(OP_RET,  16'h0000);
    do_op(OP_PUSH, 16'h003C);
    do_op(OP_POP,  16'h0000);
    toggle = 1'b0;
    repeat (3) @(negedge clk);

    // Reset lands while CALL is in its second push cycle.
    do_op(OP_LDSP, 16'h00FF);
    ev0 = acc_ev; done0 = done_cnt;
    ctl.op_valid = 1'b1; ctl.op_code = OP_CALL; ctl.op_data = 16'hCAFE;
    @(negedge clk);
    ctl.op_valid = 1'b0;
    check("rst_call_accepted", 32'(acc_ev - ev0), 1);
    @(negedge clk);
    check("rst_call_second_psh", 32'(mem_we), 1);
    rst = 1'b1;
    #1 check("rst_async_we", 32'(mem_we), 0);
    ref_mem[8'hFF] = 8'hCA; ref_sp = 8'hFF; ref_rd = 16'h0000;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - done0), 0);
    check("rst_sp", 32'(sp_addr), 32'hFF);
    check("rst_hi_byte_kept", 32'(mem[8'hFF]), 32'hCA);
    check("rst_rdata_clear", 32'(ctl.rdata), 0);
    check("rst_ready_again", 32'(ctl.op_ready), 1);

    for (int k = 0; k < 80; k++) begin
      toggle = (k >= 40) && (k < 60);
      c = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      if (c == OP_LDSP && $urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 4))
          0: d[7:0] = 8'h00;
          1: d[7:0] = 8'h01;
          2: d[7:0] = 8'h02;
          3: d[7:0] = 8'hFE;
          default: d[7:0] = 8'hFF;
        endcase
      end
      do_op(c, d);
    end
    toggle = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
